// File: rtl/glb_pkg.sv
// Shared GLB definitions: data-type codes, sequencer state encoding
// and the clogb2 width helper used by the decoder, movers and address generator.
package glb_pkg;

    localparam logic [1:0] DT_IFMAP = 2'd1;
    localparam logic [1:0] DT_PSUM  = 2'd2;
    localparam logic [1:0] DT_WGHT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1.
    function automatic int clogb2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/glb_addr_gen.sv
// GLB address sequencer: walks a rows x row_len region with a row stride and
// issues one tagged logical address per valid/ready handshake to the decoder.
// Ports:
//   i_clk, i_rst (sync, active-high), i_start, i_abort
//   i_data_type, i_base, i_row_len, i_row_cnt, i_row_stride : region config
//   i_ready : downstream accept
//   o_valid, o_addr, o_data_type, o_last : address beat
//   o_busy (RUN/DONE), o_done (1-cycle pulse), o_oob (sticky out-of-range)
module glb_addr_gen
    import glb_pkg::*;
#(
    parameter  int BANK_NUM   = 27,
    parameter  int BANK_DEPTH = 512,
    localparam int ADDR_W     = clogb2(BANK_NUM * BANK_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_data_type,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_row_len,
    input  logic [ADDR_W-1:0] i_row_cnt,
    input  logic [ADDR_W-1:0] i_row_stride,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_data_type,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_oob
);

    localparam int unsigned       WORDS    = BANK_NUM * BANK_DEPTH;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_start;

    logic start_ok;
    logic zero_size;
    logic col_end;
    logic row_end;
    logic fire;

    // Abort outranks start, so a coincident start is never accepted.
    assign start_ok  = (state == ST_IDLE) && i_start && !i_abort;
    assign zero_size = (i_row_len == '0) || (i_row_cnt == '0);
    assign col_end   = (col == len_q - ONE);
    assign row_end   = (row == cnt_q - ONE);
    assign fire      = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_valid  = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_last   = 1'b0;
        o_addr   = row_start + col;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nx = zero_size ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_last  = col_end && row_end;
                if (i_abort) begin
                    state_nx = ST_IDLE;
                end else if (fire && col_end && row_end) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            stride_q    <= '0;
            col         <= '0;
            row         <= '0;
            row_start   <= '0;
            o_data_type <= '0;
            o_oob       <= 1'b0;
        end else if (start_ok) begin
            len_q       <= i_row_len;
            cnt_q       <= i_row_cnt;
            stride_q    <= i_row_stride;
            col         <= '0;
            row         <= '0;
            row_start   <= i_base;
            o_data_type <= i_data_type;
            o_oob       <= 1'b0;
        end else if (fire && !i_abort) begin
            // The address is still issued; the flag only records it.
            if (o_addr > MAX_ADDR) begin
                o_oob <= 1'b1;
            end
            if (col_end) begin
                col       <= '0;
                row       <= row + ONE;
                row_start <= row_start + stride_q;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: tb/tb_glb_addr_gen.sv
// Self-checking bench for glb_addr_gen: directed scenarios plus randomized
// regions compared against an address list built from the region arithmetic.
module tb_glb_addr_gen;

    localparam int AW    = 14;
    localparam int MASK  = (1 << AW) - 1;
    localparam int LIMIT = 27 * 512;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [1:0]    i_data_type = '0;
    logic [AW-1:0] i_base = '0;
    logic [AW-1:0] i_row_len = '0;
    logic [AW-1:0] i_row_cnt = '0;
    logic [AW-1:0] i_row_stride = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [1:0]    o_data_type;
    logic          o_last;
    logic          o_busy;
    logic          o_done;
    logic          o_oob;

    int checks = 0;
    int errors = 0;
    bit exp_oob = 1'b0;
    int q[$];

    glb_addr_gen dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_data_type  (i_data_type),
        .i_base       (i_base),
        .i_row_len    (i_row_len),
        .i_row_cnt    (i_row_cnt),
        .i_row_stride (i_row_stride),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_addr       (o_addr),
        .o_data_type  (o_data_type),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_oob        (o_oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_addr"},  o_addr, 0);
        chk({tag, "_type"},  o_data_type, 0);
        chk({tag, "_last"},  o_last, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_oob"},   o_oob, 0);
    endtask

    // rmode: 0 ready high, 1 ready pattern 1,0,0, 2 random.
    // kill_at: beats accepted before abort/reset (-1 none).
    // inject: pulse a different start while running.
    task automatic run(input int base, input int len, input int rows,
                       input int stride, input logic [1:0] dt,
                       input int rmode, input int kill_at,
                       input bit kill_rst, input bit inject);
        int n;
        int idx;
        int cyc;
        q.delete();
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < len; c++)
                q.push_back((base + r * stride + c) & MASK);
        n = q.size();
        @(posedge clk); #1;
        i_start      = 1'b1;
        i_base       = AW'(base);
        i_row_len    = AW'(len);
        i_row_cnt    = AW'(rows);
        i_row_stride = AW'(stride);
        i_data_type  = dt;
        i_ready      = 1'b0;
        exp_oob      = 1'b0;
        if (n == 0) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            @(negedge clk);
            chk("zs_valid", o_valid, 0);
            chk("zs_done", o_done, 1);
            chk("zs_busy", o_busy, 1);
            chk("zs_oob", o_oob, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("zs_idle_done", o_done, 0);
            chk("zs_idle_busy", o_busy, 0);
            chk("zs_idle_valid", o_valid, 0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (inject && cyc == 2) begin
                i_start      = 1'b1;
                i_base       = '0;
                i_row_len    = AW'(1);
                i_row_cnt    = AW'(1);
                i_row_stride = '0;
                i_data_type  = 2'd1;
            end
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 3 == 0);
                default: i_ready = 1'($urandom % 2);
            endcase
            @(negedge clk);
            chk("valid", o_valid, 1);
            chk("addr", o_addr, q[idx]);
            chk("last", o_last, (idx == n - 1) ? 1 : 0);
            chk("type", o_data_type, dt);
            chk("busy", o_busy, 1);
            chk("done_run", o_done, 0);
            chk("oob_run", o_oob, exp_oob);
            cyc++;
            if (i_ready) begin
                if (q[idx] >= LIMIT) exp_oob = 1'b1;
                idx++;
                if (idx == kill_at) begin
                    @(posedge clk); #1;
                    i_ready = 1'b0;
                    if (kill_rst) i_rst = 1'b1;
                    else          i_abort = 1'b1;
                    @(posedge clk); #1;
                    i_rst   = 1'b0;
                    i_abort = 1'b0;
                    @(negedge clk);
                    if (kill_rst) begin
                        chk_zero("midrst");
                    end else begin
                        chk("abort_valid", o_valid, 0);
                        chk("abort_busy", o_busy, 0);
                        chk("abort_done", o_done, 0);
                        chk("abort_oob", o_oob, exp_oob);
                    end
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("abort_nodone", o_done, 0);
                    chk("abort_idle", o_busy, 0);
                    return;
                end
            end
        end
        chk("all_beats", idx, n);
        @(posedge clk); #1;
        i_ready = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        chk("done_pulse", o_done, 1);
        chk("done_valid", o_valid, 0);
        chk("done_busy", o_busy, 1);
        chk("done_oob", o_oob, exp_oob);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done", o_done, 0);
        chk("post_busy", o_busy, 0);
        chk("post_oob", o_oob, exp_oob);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        i_rst = 1'b0;

        run(100, 4, 2, 10, 2'd2, 0, -1, 1'b0, 1'b0);
        run(100, 4, 2, 10, 2'd2, 1, -1, 1'b0, 1'b0);
        run(100, 0, 3, 10, 2'd1, 0, -1, 1'b0, 1'b0);
        run(100, 3, 0, 10, 2'd3, 0, -1, 1'b0, 1'b0);
        run(200, 4, 2, 10, 2'd3, 0, 3, 1'b0, 1'b0);
        run(200, 4, 2, 10, 2'd3, 0, -1, 1'b0, 1'b0);
        run(13820, 6, 1, 0, 2'd1, 0, -1, 1'b0, 1'b0);

        // Start with abort in IDLE is not accepted; oob stays set.
        @(posedge clk); #1;
        i_start   = 1'b1;
        i_abort   = 1'b1;
        i_row_len = AW'(4);
        i_row_cnt = AW'(1);
        @(posedge clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        @(negedge clk);
        chk("sa_valid", o_valid, 0);
        chk("sa_busy", o_busy, 0);
        chk("sa_done", o_done, 0);
        chk("sa_oob", o_oob, 1);

        run(16382, 4, 1, 0, 2'd2, 2, -1, 1'b0, 1'b1);
        run(500, 5, 3, 100, 2'd1, 2, 7, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++)
            run(int'($urandom_range(0, MASK)), int'($urandom_range(1, 5)),
                int'($urandom_range(1, 4)), int'($urandom_range(0, MASK)),
                2'(int'($urandom_range(1, 3))), 2, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
